// File: rtl/mem_responder_if.sv
// Request/response bus between a memory master and mem_responder.
// The master drives the request fields and the slave returns the completion status.
interface mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        ready;
    logic        err;
    logic        busy;

    modport master (
        output req, we, adr, writedata,
        input  readdata, ready, err, busy
    );

    modport slave (
        input  req, we, adr, writedata,
        output readdata, ready, err, busy
    );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM slave with programmable wait states.
// One request is latched in IDLE. After WAIT_CYCLES further edges the read or write is
// performed, and a one-cycle ready pulse follows with readdata and err.
// Optional feature: define MEM_RESP_STATS_EN to add saturating 16-bit counters for
// successful reads, successful writes and errors.
module mem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [15:0]     o_rd_count,
    output logic [15:0]     o_wr_count,
    output logic [15:0]     o_err_count
`endif
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_ready;
    logic        r_err;
    logic        r_busy;

    logic [31:0] r_mem [DEPTH];

    logic          w_access;
    logic          w_err;
    logic [AW-1:0] w_idx;

    // The access edge is the last WAIT edge; err is decided from the latched address.
    assign w_access = (r_state == StWait) && (r_cnt == 8'd0);
    assign w_err    = (r_adr[1:0] != 2'b00) || (r_adr[31:2] >= 30'(DEPTH));
    assign w_idx    = r_adr[AW+1:2];

    // Control FSM: latch the request, count down the wait states, access, then respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
            r_we    <= 1'b0;
            r_adr   <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_adr   <= bus.adr;
                        r_wdata <= bus.writedata;
                        r_cnt   <= WAIT_INIT;
                        r_busy  <= 1'b1;
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= StResp;
                        if (w_err) begin
                            r_err   <= 1'b1;
                            r_rdata <= 32'd0;
                        end else begin
                            r_err   <= 1'b0;
                            // A write returns zero; the RAM update itself happens in the array block.
                            r_rdata <= r_we ? 32'd0 : r_mem[w_idx];
                        end
                    end
                end
                StResp: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // RAM write port. There is no reset, so the contents survive rst_n.
    always_ff @(posedge clk) begin
        if (w_access && r_we && !w_err) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

`ifdef MEM_RESP_STATS_EN
    logic [15:0] r_rd_cnt;
    logic [15:0] r_wr_cnt;
    logic [15:0] r_err_cnt;

    // Saturating access statistics, updated on the access edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_cnt  <= 16'd0;
            r_wr_cnt  <= 16'd0;
            r_err_cnt <= 16'd0;
        end else if (w_access) begin
            if (w_err) begin
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end else if (r_we) begin
                if (r_wr_cnt != 16'hFFFF) r_wr_cnt <= r_wr_cnt + 16'd1;
            end else begin
                if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
            end
        end
    end

    assign o_rd_count  = r_rd_cnt;
    assign o_wr_count  = r_wr_cnt;
    assign o_err_count = r_err_cnt;
`endif

    assign bus.readdata = r_rdata;
    assign bus.ready    = r_ready;
    assign bus.err      = r_err;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a timeline model with one compare process, plus directed literal checks.
module tb_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus ();
    mem_responder_if bus0 ();

`ifdef MEM_RESP_STATS_EN
    logic [15:0] rd_c, wr_c, er_c, rd_c0, wr_c0, er_c0;
`endif

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_RESP_STATS_EN
        ,
        .o_rd_count  (rd_c),
        .o_wr_count  (wr_c),
        .o_err_count (er_c)
`endif
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
`ifdef MEM_RESP_STATS_EN
        ,
        .o_rd_count  (rd_c0),
        .o_wr_count  (wr_c0),
        .o_err_count (er_c0)
`endif
    );

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Timeline model: a request accepted at edge a completes at edge a+W+1, and the next
    // request can be accepted at edge a+W+3.
    int          cyc   = 0;
    bit          m_act = 0;
    int          m_acc = 0;
    bit          m_we;
    logic [31:0] m_adr, m_wd, m_data;
    bit          m_err;
    logic [31:0] m_mem [DEPTH];
    int          m_rd = 0, m_wr = 0, m_er = 0;

    initial begin : model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_act = 0;
                m_rd  = 0;
                m_wr  = 0;
                m_er  = 0;
            end else begin
                cyc++;
                if (m_act && cyc == m_acc + W + 1) begin
                    m_err = (m_adr[1:0] != 2'b00) || ({2'b00, m_adr[31:2]} >= 32'(DEPTH));
                    if (m_err) begin
                        m_data = 32'd0;
                        m_er++;
                    end else if (m_we) begin
                        m_mem[m_adr[7:2]] = m_wd;
                        m_data = 32'd0;
                        m_wr++;
                    end else begin
                        m_data = m_mem[m_adr[7:2]];
                        m_rd++;
                    end
                end
                if ((!m_act || cyc >= m_acc + W + 3) && bus.req) begin
                    m_act = 1;
                    m_acc = cyc;
                    m_we  = bus.we;
                    m_adr = bus.adr;
                    m_wd  = bus.writedata;
                end
            end
        end
    end

    // Compare the DUT outputs against the model on every cycle outside reset.
    initial begin : cmp
        forever begin
            @(negedge clk);
            if (rst_n) begin
                bit e_ready, e_busy;
                e_busy  = m_act && cyc >= m_acc && cyc <= m_acc + W + 1;
                e_ready = m_act && cyc == m_acc + W + 1;
                chk("ready", 32'(bus.ready), 32'(e_ready));
                chk("busy", 32'(bus.busy), 32'(e_busy));
                if (e_ready) begin
                    chk("err", 32'(bus.err), 32'(m_err));
                    chk("readdata", bus.readdata, m_data);
                end
            end
        end
    end

    task automatic txn(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                       input string name, output logic [31:0] rd, output logic er);
        int k;
        bus.req       = 1'b1;
        bus.we        = we;
        bus.adr       = adr;
        bus.writedata = wd;
        @(negedge clk);
        // Scramble the inputs after acceptance; they must not matter.
        bus.req       = 1'b0;
        bus.we        = ~we;
        bus.adr       = 32'hFFFF_FFFC;
        bus.writedata = ~wd;
        k = 0;
        while (!bus.ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({name, " latency"}, 32'(k), 32'(W + 1));
        rd = bus.readdata;
        er = bus.err;
        @(negedge clk);
    endtask

    initial begin : main
        logic [31:0] rd;
        logic        er;
        int          t[$];
        logic [31:0] d[$];
        int          base, j;

        bus.req = 0; bus.we = 0; bus.adr = 0; bus.writedata = 0;
        bus0.req = 0; bus0.we = 0; bus0.adr = 0; bus0.writedata = 0;
        repeat (3) @(negedge clk);
        chk("rst ready", 32'(bus.ready), 32'd0);
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst err", 32'(bus.err), 32'd0);
        chk("rst readdata", bus.readdata, 32'd0);
        chk("rst0 ready", 32'(bus0.ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait instance: ready is high between edges 1 and 2 after acceptance.
        for (int i = 0; i < 2; i++) begin
            bus0.req       = 1'b1;
            bus0.we        = (i == 0);
            bus0.adr       = 32'h4;
            bus0.writedata = 32'h1234_5678;
            @(negedge clk);
            bus0.req = 1'b0;
            chk("w0 busy", 32'(bus0.busy), 32'd1);
            chk("w0 ready early", 32'(bus0.ready), 32'd0);
            @(negedge clk);
            chk("w0 ready", 32'(bus0.ready), 32'd1);
            chk("w0 err", 32'(bus0.err), 32'd0);
            chk("w0 readdata", bus0.readdata, (i == 0) ? 32'd0 : 32'h1234_5678);
            @(negedge clk);
            chk("w0 ready drop", 32'(bus0.ready), 32'd0);
            chk("w0 busy drop", 32'(bus0.busy), 32'd0);
        end

        // Preload, then read back a word written in the immediately preceding transaction.
        txn(1, 32'h00, 32'h1111_1111, "wr00", rd, er);
        txn(1, 32'h04, 32'h2222_2222, "wr04", rd, er);
        txn(1, 32'h10, 32'hA5A5_A5A5, "wr10", rd, er);
        txn(1, 32'h08, 32'hDEAD_BEEF, "wr08", rd, er);
        chk("wr08 readdata", rd, 32'd0);
        txn(0, 32'h08, 32'h0, "rd08", rd, er);
        chk("rd08 data", rd, 32'hDEAD_BEEF);
        chk("rd08 err", 32'(er), 32'd0);

        // Reset in the middle of a write's wait: the write must be dropped.
        bus.req = 1'b1; bus.we = 1'b1; bus.adr = 32'h10; bus.writedata = 32'h0BAD_F00D;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst busy", 32'(bus.busy), 32'd0);
        chk("midrst ready", 32'(bus.ready), 32'd0);
        chk("midrst readdata", bus.readdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        txn(0, 32'h10, 32'h0, "rd10", rd, er);
        chk("rd10 data kept", rd, 32'hA5A5_A5A5);
        chk("rd10 err", 32'(er), 32'd0);

        // Error cases: misaligned and out of range; then a good read.
        txn(0, 32'h0A, 32'h0, "rd0a", rd, er);
        chk("rd0a err", 32'(er), 32'd1);
        chk("rd0a data", rd, 32'd0);
        txn(0, 32'h100, 32'h0, "rd100", rd, er);
        chk("rd100 err", 32'(er), 32'd1);
        chk("rd100 data", rd, 32'd0);
        txn(0, 32'h00, 32'h0, "rd00", rd, er);
        chk("rd00 data", rd, 32'h1111_1111);
        chk("rd00 err", 32'(er), 32'd0);

        // req held high for three reads; adr only changes while a transaction is in WAIT.
        bus.req = 1'b1; bus.we = 1'b0; bus.adr = 32'h00;
        base = cyc + 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            j = cyc - base;
            if (bus.ready) begin
                t.push_back(j);
                d.push_back(bus.readdata);
            end
            if (j == 0) bus.adr = 32'h04;
            if (j == 5) bus.adr = 32'h08;
            if (j == 10) bus.req = 1'b0;
        end
        chk("held count", 32'(t.size()), 32'd3);
        if (t.size() == 3) begin
            chk("held first", 32'(t[0]), 32'd3);
            chk("held gap1", 32'(t[1] - t[0]), 32'd5);
            chk("held gap2", 32'(t[2] - t[1]), 32'd5);
            chk("held d0", d[0], 32'h1111_1111);
            chk("held d1", d[1], 32'h2222_2222);
            chk("held d2", d[2], 32'hDEAD_BEEF);
        end

`ifdef MEM_RESP_STATS_EN
        // Counters restarted at the mid-wait reset: 5 reads, 0 writes, 2 errors since then.
        chk("rd_count", 32'(rd_c), 32'd5);
        chk("wr_count", 32'(wr_c), 32'd0);
        chk("err_count", 32'(er_c), 32'd2);
        chk("rd_count model", 32'(rd_c), 32'(m_rd));
        chk("err_count model", 32'(er_c), 32'(m_er));
        chk("rd_count0", 32'(rd_c0), 32'd0);
        chk("wr_count0", 32'(wr_c0), 32'd0);
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-addressed memory slave that serves the processor's data/instruction memory port through a req/ready handshake with programmable wait states.
- Sits between the multi-cycle core's memory interface and on-chip RAM. Replaces the zero-latency combinational memory when realistic access timing is needed.
- Latches one request, waits WAIT_CYCLES, performs the read or write, then returns a one-cycle ready pulse with data and error status.

Parameters:
DEPTH, 64, number of 32-bit words in the RAM (power of two, 2..4096)
WAIT_CYCLES, 2, extra cycles between request acceptance and RAM access (0..255)

Ports:
clk  input  1  clock, all state updates on posedge
reset  input  1  asynchronous active-low reset; asserted when 0
req  input  1  request strobe; sampled only in IDLE
we  input  1  1 = write, 0 = read; sampled with req
adr  input  32  byte address; word index = adr[31:2]
writedata  input  32  write data; sampled with req
readdata  output  32  read data; valid only while ready=1
ready  output  1  one-cycle completion pulse
err  output  1  error flag; valid only while ready=1
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (reset=0, async): FSM to IDLE, counter=0, readdata=0, ready=0, err=0, busy=0. Latched request is discarded; a pending write is never committed. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req=1: latch we, adr, writedata; cnt<=WAIT_CYCLES; go to WAIT. IDLE, req=0: stay.
- WAIT, cnt!=0: cnt<=cnt-1.
- WAIT, cnt==0: perform access on this edge, then go to RESP.
  - Write: RAM[idx]<=wd; readdata<=0.
  - Read: readdata<=RAM[idx].
- RESP: ready=1, busy=1 for exactly one cycle; next state is IDLE unconditionally.
- Latency: with req sampled at edge 0, ready is high between edges WAIT_CYCLES+1 and WAIT_CYCLES+2. Minimum transaction period is WAIT_CYCLES+3 cycles.
- req is ignored in WAIT and RESP. A request held high through RESP is re-accepted on the first IDLE edge.
- Inputs changing after acceptance have no effect.
- Error: misaligned (adr[1:0]!=0) or out of range (adr[31:2]>=DEPTH).
  - No RAM access; readdata<=0; err<=1 with the ready pulse.
  - Otherwise err=0.
- Read-after-write to the same word in consecutive transactions returns the new data.
- readdata holds its value after RESP until the next access edge. Consumers use it only while ready=1.
- cnt is 8 bits; no wrap occurs because cnt is loaded only in IDLE.

Optional Feature:
MEM_RESP_STATS_EN
- Defined: adds outputs rd_count, wr_count, err_count (16 bits each).
  - Each increments on the access edge for successful reads, successful writes, and errors respectively.
  - Each saturates at 16'hFFFF and resets to 0 on reset.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset low mid-WAIT of a write to 0x10, release, then read 0x10 -> ready after 4 cycles; readdata equals the pre-reset content (write dropped); err=0.
- WAIT_CYCLES=2: write 0xDEADBEEF to 0x08, then read 0x08 -> ready high exactly in the 4th cycle after each accept edge; read returns 0xDEADBEEF; busy high for 4 cycles per transaction.
- Read 0x0A (misaligned) and read 0x100 with DEPTH=64 -> ready with err=1, readdata=0. A following read of 0x00 returns RAM[0] with err=0.
- req held high continuously for 3 reads of 0x00, 0x04, 0x08 -> three ready pulses spaced 5 cycles apart; changing adr during WAIT has no effect.
- WAIT_CYCLES=0 build: read accepted at edge 0 -> ready high between edges 1 and 2.
- MEM_RESP_STATS_EN defined: 2 writes, 3 reads, 1 misaligned access -> wr_count=2, rd_count=3, err_count=1. Forcing err_count to 0xFFFF then one more error -> err_count stays 0xFFFF.
